// File: rtl/vram_port_ctrl.sv
// CPU-side VRAM data port: auto-incrementing address, read prefetch, posted write, req/ack master.
// Optional VRAM_PORT_DECR_EN: ADDR_H[3] makes auto-steps subtract instead of add.
module vram_port_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        reg_addr,
  input  logic [7:0]        reg_wrdata,
  input  logic              reg_write,
  input  logic              reg_read,
  output logic [7:0]        reg_rddata,
  output logic              busy,
  output logic              ovf,
  output logic              vram_req,
  output logic              vram_write,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wrdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rddata
);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [3:0]          incr_q, incr_d;
  logic [7:0]          pbuf_q, pbuf_d;
  logic [7:0]          wbuf_q, wbuf_d;
  logic                wfull_q, wfull_d;
  logic                pend_q, pend_d;
  logic                stale_q, stale_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          rddata_q, rd_mux;
  logic [ADDR_W-1:0]   step, stepped_addr;
  logic                decr;
  logic                addr_wr, data_wr, data_rd, ack_wr, ack_rd, stale_now;
  logic                unused_wrdata;

  assign unused_wrdata = ^reg_wrdata[3:1];

`ifdef VRAM_PORT_DECR_EN
  logic decr_q, decr_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) decr_q <= 1'b0;
    else        decr_q <= decr_d;
  end
  always_comb begin
    decr_d = decr_q;
    if (reg_write && reg_addr == 3'd2) decr_d = reg_wrdata[3];
  end
  assign decr = decr_q;
`else
  assign decr = 1'b0;
`endif

  assign addr_wr = reg_write && (reg_addr <= 3'd2);
  assign data_wr = reg_write && (reg_addr == 3'd3);
  assign data_rd = reg_read && (reg_addr == 3'd3);
  assign ack_wr  = (state_q == StWr) && vram_ack;
  assign ack_rd  = (state_q == StRd) && vram_ack;

  // Any address change while a read is in flight makes its data refer to the wrong location.
  assign stale_now = stale_q || ((state_q == StRd) && (addr_wr || data_rd));

  assign step         = (incr_q == 4'd0) ? '0 : (ADDR_W'(1) << (incr_q - 4'd1));
  assign stepped_addr = decr ? (addr_q - step) : (addr_q + step);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_addr_d = req_addr_q;
    incr_d     = incr_q;
    pbuf_d     = pbuf_q;
    wbuf_d     = wbuf_q;
    wfull_d    = wfull_q;
    pend_d     = pend_q;
    stale_d    = stale_q;
    ovf_d      = ovf_q;

    if (ack_rd) begin
      if (!stale_now) begin
        pbuf_d = vram_rddata;
        pend_d = 1'b0;
      end
      stale_d = 1'b0;
    end
    if (ack_wr) begin
      wfull_d = 1'b0;
      pend_d  = 1'b1;
    end

    // A register write to the address takes priority over any same-cycle step.
    if (addr_wr) begin
      case (reg_addr)
        3'd0:    addr_d[7:0]  = reg_wrdata;
        3'd1:    addr_d[15:8] = reg_wrdata;
        default: begin
          addr_d[ADDR_W-1] = reg_wrdata[0];
          incr_d           = reg_wrdata[7:4];
          ovf_d            = 1'b0;
        end
      endcase
    end else if (ack_wr || data_rd) begin
      addr_d = stepped_addr;
    end

    if (addr_wr || data_rd) begin
      pend_d = 1'b1;
      if ((state_q == StRd) && !ack_rd) stale_d = 1'b1;
    end

    if (data_wr) begin
      if (wfull_q) begin
        ovf_d = 1'b1;
      end else begin
        wbuf_d  = reg_wrdata;
        wfull_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (wfull_d) begin
          state_d    = StWr;
          req_addr_d = addr_d;
        end else if (pend_d) begin
          state_d    = StRd;
          req_addr_d = addr_d;
        end
      end
      StWr, StRd: begin
        if (vram_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_mux = 8'h00;
    case (reg_addr)
      3'd0:    rd_mux = addr_q[7:0];
      3'd1:    rd_mux = addr_q[15:8];
      3'd2:    rd_mux = {incr_q, decr, 2'b00, addr_q[ADDR_W-1]};
      3'd3:    rd_mux = pbuf_q;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      req_addr_q <= '0;
      incr_q     <= 4'd0;
      pbuf_q     <= 8'h00;
      wbuf_q     <= 8'h00;
      wfull_q    <= 1'b0;
      pend_q     <= 1'b0;
      stale_q    <= 1'b0;
      ovf_q      <= 1'b0;
      rddata_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_addr_q <= req_addr_d;
      incr_q     <= incr_d;
      pbuf_q     <= pbuf_d;
      wbuf_q     <= wbuf_d;
      wfull_q    <= wfull_d;
      pend_q     <= pend_d;
      stale_q    <= stale_d;
      ovf_q      <= ovf_d;
      rddata_q   <= rd_mux;
    end
  end

  assign vram_req    = (state_q != StIdle);
  assign vram_write  = (state_q == StWr);
  assign vram_addr   = req_addr_q;
  assign vram_wrdata = (state_q == StWr) ? wbuf_q : 8'h00;
  assign busy        = vram_req || wfull_q;
  assign ovf         = ovf_q;
  assign reg_rddata  = rddata_q;

endmodule

// File: tb/tb_vram_port_ctrl.sv
// Directed bench for vram_port_ctrl with a behavioural VRAM arbiter (programmable ack delay).
// Decrement checks are compiled in when VRAM_PORT_DECR_EN is defined.
module tb_vram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  reg_addr = 3'd0;
  logic [7:0]  reg_wrdata = 8'h00;
  logic        reg_write = 1'b0;
  logic        reg_read = 1'b0;
  logic [7:0]  reg_rddata;
  logic        busy, ovf, vram_req, vram_write;
  logic [16:0] vram_addr;
  logic [7:0]  vram_wrdata;
  logic        vram_ack = 1'b0;
  logic [7:0]  vram_rddata = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:131071];
  logic [16:0] log_addr [0:255];
  logic        log_wr [0:255];
  logic [7:0]  log_data [0:255];
  int          log_n = 0;
  int          ack_delay = 0;
  int          unstable = 0;

  vram_port_ctrl #(.ADDR_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_wrdata(reg_wrdata),
    .reg_write(reg_write), .reg_read(reg_read), .reg_rddata(reg_rddata), .busy(busy),
    .ovf(ovf), .vram_req(vram_req), .vram_write(vram_write), .vram_addr(vram_addr),
    .vram_wrdata(vram_wrdata), .vram_ack(vram_ack), .vram_rddata(vram_rddata)
  );

  always #20 clk = ~clk;

  // Arbiter model: acks after ack_delay held cycles, logs every completed request.
  initial begin : arbiter
    int          cnt;
    logic        hold;
    logic [16:0] h_addr;
    logic        h_wr;
    logic [7:0]  h_data;
    for (int i = 0; i < 131072; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[17'h12] = 8'hA0; mem[17'h13] = 8'hA1; mem[17'h14] = 8'hA2; mem[17'h15] = 8'hA3;
    cnt = 0; hold = 1'b0; h_addr = '0; h_wr = 1'b0; h_data = '0;
    forever begin
      @(negedge clk);
      if (vram_req && rst_n) begin
        if (!hold) begin
          h_addr = vram_addr; h_wr = vram_write; h_data = vram_wrdata; hold = 1'b1;
        end else if (h_addr !== vram_addr || h_wr !== vram_write || h_data !== vram_wrdata) begin
          unstable++;
        end
        if (cnt >= ack_delay) begin
          vram_ack = 1'b1;
          vram_rddata = mem[vram_addr];
          if (vram_write) mem[vram_addr] = vram_wrdata;
          if (log_n < 256) begin
            log_addr[log_n] = vram_addr; log_wr[log_n] = vram_write;
            log_data[log_n] = vram_wrdata;
          end
          log_n++;
          cnt = 0; hold = 1'b0;
        end else begin
          vram_ack = 1'b0;
          cnt++;
        end
      end else begin
        vram_ack = 1'b0; cnt = 0; hold = 1'b0;
      end
    end
  end

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_addr = a; reg_wrdata = d; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk);
    reg_addr = a;
    @(negedge clk);
    v = reg_rddata;
  endtask

  // Samples DATA, then strobes reg_read to complete the access.
  task automatic data_read(output logic [7:0] v);
    @(negedge clk);
    reg_addr = 3'd3;
    @(negedge clk);
    v = reg_rddata;
    reg_read = 1'b1;
    @(negedge clk);
    reg_read = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy && !vram_req) quiet++;
      else quiet = 0;
    end
    vectors++;
    if (quiet < 3) begin
      miscompares++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({vram_req, vram_write, busy, ovf} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 0000", {vram_req, vram_write, busy, ovf});
    end
    vectors++;
    if (reg_rddata !== 8'h00 || vram_addr !== 17'h0 || vram_wrdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_buses: got rd=%h addr=%h wd=%h required 0", reg_rddata, vram_addr,
               vram_wrdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_seq_read;
    logic [7:0] v;
    logic [7:0] exp_d [0:3];
    exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2; exp_d[3] = 8'hA3;
    ack_delay = 0;
    reg_wr(3'd0, 8'h12); reg_wr(3'd1, 8'h00); reg_wr(3'd2, 8'h10);
    wait_idle(100);
    for (int i = 0; i < 4; i++) begin
      data_read(v);
      vectors++;
      if (v !== exp_d[i]) begin
        miscompares++;
        $display("FAIL seq_read[%0d]: got %h required %h", i, v, exp_d[i]);
      end
      wait_idle(100);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (log_addr[log_n-5+i] !== 17'h12 + 17'(i) || log_wr[log_n-5+i] !== 1'b0) begin
        miscompares++;
        $display("FAIL seq_req[%0d]: got addr=%h wr=%b required addr=%h wr=0", i,
                 log_addr[log_n-5+i], log_wr[log_n-5+i], 17'h12 + 17'(i));
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    int base;
    ack_delay = 0;
    reg_wr(3'd0, 8'hFF); reg_wr(3'd1, 8'hFF); reg_wr(3'd2, 8'h11);
    wait_idle(100);
    base = log_n;
    reg_wr(3'd3, 8'h5A);
    wait_idle(100);
    vectors++;
    if (log_n - base != 2 || log_wr[base] !== 1'b1 || log_addr[base] !== 17'h1FFFF ||
        log_data[base] !== 8'h5A) begin
      miscompares++;
      $display("FAIL wrap_write: got n=%0d wr=%b addr=%h data=%h required n=2 wr=1 addr=1ffff data=5a",
               log_n - base, log_wr[base], log_addr[base], log_data[base]);
    end
    vectors++;
    if (log_wr[base+1] !== 1'b0 || log_addr[base+1] !== 17'h0) begin
      miscompares++;
      $display("FAIL wrap_fetch: got wr=%b addr=%h required wr=0 addr=00000", log_wr[base+1],
               log_addr[base+1]);
    end
    rd_reg(3'd2, v);
    vectors++;
    if (v !== 8'h10) begin
      miscompares++;
      $display("FAIL wrap_addr_h: got %h required 10", v);
    end
    rd_reg(3'd0, v);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap_addr_l: got %h required 00", v);
    end
    rd_reg(3'd3, v);
    vectors++;
    if (v !== 8'h5A) begin
      miscompares++;
      $display("FAIL wrap_data: got %h required 5a", v);
    end
  endtask

  task automatic test_overflow;
    int base;
    ack_delay = 0;
    reg_wr(3'd0, 8'h80); reg_wr(3'd1, 8'h00); reg_wr(3'd2, 8'h10);
    wait_idle(100);
    ack_delay = 10;
    base = log_n;
    reg_wr(3'd3, 8'h11); reg_wr(3'd3, 8'h22); reg_wr(3'd3, 8'h33);
    vectors++;
    if (ovf !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: got ovf=%b busy=%b required 1 1", ovf, busy);
    end
    wait_idle(200);
    vectors++;
    if (log_n - base != 2 || log_wr[base] !== 1'b1 || log_addr[base] !== 17'h80 ||
        log_data[base] !== 8'h11) begin
      miscompares++;
      $display("FAIL ovf_write: got n=%0d wr=%b addr=%h data=%h required n=2 wr=1 addr=80 data=11",
               log_n - base, log_wr[base], log_addr[base], log_data[base]);
    end
    vectors++;
    if (mem[17'h80] !== 8'h11 || mem[17'h81] !== 8'hDB) begin
      miscompares++;
      $display("FAIL ovf_mem: got %h %h required 11 db", mem[17'h80], mem[17'h81]);
    end
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: got %b required 1", ovf);
    end
    ack_delay = 0;
    reg_wr(3'd2, 8'h10);
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %b required 0", ovf);
    end
    wait_idle(100);
    vectors++;
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL req_stable: got %0d changes while held required 0", unstable);
    end
  endtask

  task automatic test_stale;
    logic [7:0] v;
    int base;
    ack_delay = 0;
    reg_wr(3'd0, 8'h10); reg_wr(3'd1, 8'h00);
    wait_idle(100);
    ack_delay = 4;
    base = log_n;
    reg_wr(3'd2, 8'h10);
    reg_wr(3'd0, 8'h40);
    wait_idle(200);
    vectors++;
    if (log_n - base != 2 || log_addr[base] !== 17'h10 || log_addr[base+1] !== 17'h40 ||
        log_wr[base+1] !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_reqs: got n=%0d a0=%h a1=%h required n=2 a0=10 a1=40", log_n - base,
               log_addr[base], log_addr[base+1]);
    end
    ack_delay = 0;
    data_read(v);
    vectors++;
    if (v !== 8'h1A) begin
      miscompares++;
      $display("FAIL stale_data: got %h required 1a", v);
    end
    wait_idle(100);
  endtask

  task automatic test_step;
    logic [7:0] v;
    int base;
    ack_delay = 0;
    reg_wr(3'd0, 8'h00); reg_wr(3'd1, 8'hC0); reg_wr(3'd2, 8'hF1);
    wait_idle(100);
    base = log_n;
    data_read(v);
    wait_idle(100);
    vectors++;
    if (v !== 8'h5A || log_n - base != 1 || log_addr[base] !== 17'h0) begin
      miscompares++;
      $display("FAIL step_max: got data=%h n=%0d addr=%h required 5a 1 00000", v, log_n - base,
               log_addr[base]);
    end
    rd_reg(3'd2, v);
    vectors++;
    if (v !== 8'hF0) begin
      miscompares++;
      $display("FAIL step_addr_h: got %h required f0", v);
    end
    reg_wr(3'd0, 8'h00); reg_wr(3'd1, 8'h00); reg_wr(3'd2, 8'h18);
    wait_idle(100);
    base = log_n;
    data_read(v);
    wait_idle(100);
`ifdef VRAM_PORT_DECR_EN
    vectors++;
    if (log_n - base != 1 || log_addr[base] !== 17'h1FFFF) begin
      miscompares++;
      $display("FAIL decr_wrap: got n=%0d addr=%h required 1 1ffff", log_n - base, log_addr[base]);
    end
    rd_reg(3'd2, v);
    vectors++;
    if (v !== 8'h19) begin
      miscompares++;
      $display("FAIL decr_addr_h: got %h required 19", v);
    end
`else
    vectors++;
    if (log_n - base != 1 || log_addr[base] !== 17'h1) begin
      miscompares++;
      $display("FAIL decr_ignored: got n=%0d addr=%h required 1 00001", log_n - base,
               log_addr[base]);
    end
    rd_reg(3'd2, v);
    vectors++;
    if (v !== 8'h10) begin
      miscompares++;
      $display("FAIL decr_bit_reads0: got %h required 10", v);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    logic [7:0] got [0:3];
    ack_delay = 10;
    reg_wr(3'd3, 8'h77); reg_wr(3'd3, 8'h88);
    vectors++;
    if (vram_req !== 1'b1 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: got req=%b ovf=%b required 1 1", vram_req, ovf);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({vram_req, busy, ovf} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid: got req/busy/ovf=%b required 000", {vram_req, busy, ovf});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    for (int i = 0; i < 4; i++) begin
      rd_reg(3'(i), v);
      got[i] = v;
    end
    vectors++;
    if (got[0] !== 8'h00 || got[1] !== 8'h00 || got[2] !== 8'h00 || got[3] !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_regs: got %h %h %h %h required 00 00 00 00", got[0], got[1], got[2],
               got[3]);
    end
  endtask

  initial begin
    test_reset();
    test_seq_read();
    test_wrap();
    test_overflow();
    test_stale();
    test_step();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
